horner_poly_pipe: RTL and testbench
===================================

// Module: horner_poly_pipe
// PURPOSE
//  Fully pipelined, parametrised Horner-form polynomial evaluator:
//    y = c0 + x*(c1 + x*(c2 + ... + x*cN)), N = DEGREE.
//  Generalises the fixed 5th-order exp(x) Taylor datapath: degree is a parameter,
//  coefficients are runtime-loadable through a double-buffered bank, and the
//  stream interface has real backpressure. One sample per cycle when unstalled.
// PARAMETERS
//  WIDTHIN   16  x and coefficient width, unsigned Q(WIDTHIN-FRAC_IN).FRAC_IN
//  FRAC_IN   14  fractional bits of x and coefficients
//  WIDTHOUT  32  accumulator/output width, unsigned Q(WIDTHOUT-FRAC_OUT).FRAC_OUT
//  FRAC_OUT  25  fractional bits of accumulator; FRAC_OUT >= FRAC_IN
//  DEGREE     5  polynomial order N, 1..15; AW = $clog2(DEGREE+1)
// PORTS
//  clk            in   1         clock, rising edge
//  reset          in   1         asynchronous, active-high
//  i_valid        in   1         input sample valid
//  o_ready        out  1         block accepts i_x this cycle
//  i_x            in   WIDTHIN   input sample
//  o_valid        out  1         o_y valid
//  i_ready        in   1         downstream accepts o_y
//  o_y            out  WIDTHOUT  result
//  i_coef_we      in   1         write i_coef_data to shadow[i_coef_addr]
//  i_coef_addr    in   AW        coefficient index k (c_k); addr > DEGREE ignored
//  i_coef_data    in   WIDTHIN   coefficient value
//  i_coef_commit  in   1         request shadow->active copy
//  o_coef_busy    out  1         commit in progress (state != RUN)
// BEHAVIOUR
//  Reset: o_valid=0, o_y=0, all stage valids/data 0, FSM=RUN, o_coef_busy=0;
//    active & shadow banks = exp Taylor set c0..c5 = 0x4000,0x4000,0x2000,0x0AAA,
//    0x02AA,0x0088 (k<=DEGREE); c_k=0 for k>5. Reset mid-operation drops in-flight data.
//  Handshake: adv = i_ready | ~o_valid; every pipeline register moves only when adv.
//    o_ready = adv & (state==RUN). Accept = i_valid & o_ready. o_valid independent of i_ready.
//    o_y/o_valid hold steady while o_valid & ~i_ready.
//  Datapath: stage 0 registers x and acc0 = c_N << (FRAC_OUT-FRAC_IN).
//    Stage pair j=1..N: M-reg p = (acc*x)[FRAC_IN+WIDTHOUT-1:FRAC_IN] (truncate);
//    A-reg acc = p + (c_{N-j} << (FRAC_OUT-FRAC_IN)), modulo 2^WIDTHOUT.
//    x and valid travel alongside. Latency 2*DEGREE+1 accepted-to-o_valid cycles (11 default).
//  Coefficients: active bank read combinationally by each stage; shadow writes any
//    time, never disturb active. FSM:
//    RUN   -> DRAIN on i_coef_commit (o_ready drops next cycle).
//    DRAIN -> SWAP when all stage valids and o_valid are 0.
//    SWAP  : active <= shadow (1 cycle) -> RUN.
//    Commit while DRAIN/SWAP ignored. Shadow write in same cycle as commit is included;
//    write during SWAP cycle is not (lands in shadow only).
//  Every sample is computed entirely with one coefficient set.
// CONFIGURATION
//  HORNER_SAT_EN defined: each A-reg add and each M-reg truncation saturates to
//    2^WIDTHOUT-1 on overflow (carry-out, or nonzero product bits above the kept field).
//  Not defined: wrap-around, only low WIDTHOUT bits kept (default).
// TESTING
//  T1 reset defaults, i_ready=1, x=0x0000 -> o_y=0x02000000 (1.0) after exactly 11 cycles.
//  T2 write c1=0x4000, others 0, commit, x=0x2000 -> o_y=0x01000000; o_coef_busy 1 until swap.
//  T3 100 back-to-back random x, i_ready random 50% -> no loss/dup, order kept, match model.
//  T4 commit with 11 samples in flight -> o_ready=0 until drained; old samples use old set.
//  T5 all c=0xFFFF, x=0xFFFF: SAT_EN -> o_y=0xFFFFFFFF; else wrapped bit-accurate model.
//  T6 reset asserted with pipe full -> o_valid=0 next cycle; banks return to exp defaults.

Source files
------------

// File: rtl/horner_poly_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : horner_poly_pipe                                             |
// | Description : Fully pipelined Horner-form polynomial evaluator,            |
// |               y = c0 + x*(c1 + x*(c2 + ... + x*cN)).                       |
// |               Provides a double-buffered runtime coefficient bank and a    |
// |               valid/ready stream interface with backpressure.              |
// |               Optional macro HORNER_SAT_EN: saturate multiply truncation   |
// |               and coefficient adds instead of wrapping.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module horner_poly_pipe #(
  parameter int WIDTHIN  = 16,
  parameter int FRAC_IN  = 14,
  parameter int WIDTHOUT = 32,
  parameter int FRAC_OUT = 25,
  parameter int DEGREE   = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [WIDTHIN-1:0]            i_x,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [WIDTHOUT-1:0]           o_y,
  input  logic                          i_coef_we,
  input  logic [$clog2(DEGREE+1)-1:0]   i_coef_addr,
  input  logic [WIDTHIN-1:0]            i_coef_data,
  input  logic                          i_coef_commit,
  output logic                          o_coef_busy
);

  localparam int SHIFT = FRAC_OUT - FRAC_IN;
  localparam int PW    = WIDTHOUT + WIDTHIN;
  // x is only needed up to the last multiply stage
  localparam int XLEN  = 2 * DEGREE - 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_t;

  // Reset contents of both banks: the exp(x) Taylor coefficients
  function automatic logic [WIDTHIN-1:0] default_coef(input int k);
    case (k)
      0:       return WIDTHIN'(16'h4000);
      1:       return WIDTHIN'(16'h4000);
      2:       return WIDTHIN'(16'h2000);
      3:       return WIDTHIN'(16'h0AAA);
      4:       return WIDTHIN'(16'h02AA);
      5:       return WIDTHIN'(16'h0088);
      default: return '0;
    endcase
  endfunction

  // Align a Q.FRAC_IN coefficient to the Q.FRAC_OUT accumulator grid
  function automatic logic [WIDTHOUT-1:0] coef_ext(input logic [WIDTHIN-1:0] c);
    return WIDTHOUT'(c) << SHIFT;
  endfunction

  // acc*x re-scaled back to FRAC_OUT by dropping FRAC_IN low bits
  function automatic logic [WIDTHOUT-1:0] mul_trunc(input logic [WIDTHOUT-1:0] a,
                                                    input logic [WIDTHIN-1:0]  b);
    logic [PW-1:0] full;
    full = PW'(a) * PW'(b);
`ifdef HORNER_SAT_EN
    if ((full >> (FRAC_IN + WIDTHOUT)) != '0) return {WIDTHOUT{1'b1}};
`endif
    return WIDTHOUT'(full >> FRAC_IN);
  endfunction

  function automatic logic [WIDTHOUT-1:0] add_coef(input logic [WIDTHOUT-1:0] a,
                                                   input logic [WIDTHIN-1:0]  c);
`ifdef HORNER_SAT_EN
    logic [WIDTHOUT:0] sum;
    sum = {1'b0, a} + {1'b0, coef_ext(c)};
    return sum[WIDTHOUT] ? {WIDTHOUT{1'b1}} : sum[WIDTHOUT-1:0];
`else
    return a + coef_ext(c);
`endif
  endfunction

  // Coefficient banks
  logic [WIDTHIN-1:0]  active [0:DEGREE];
  logic [WIDTHIN-1:0]  shadow [0:DEGREE];

  // Pipeline: index 0 is the entry stage, index j the A-reg of pair j
  logic [WIDTHOUT-1:0] acc_q  [0:DEGREE];
  logic [DEGREE:0]     va_q;
  logic [WIDTHOUT-1:0] prod_q [1:DEGREE];
  logic [DEGREE:1]     vm_q;
  logic [WIDTHIN-1:0]  xs_q   [0:XLEN-1];
  logic [WIDTHOUT-1:0] prod_d [1:DEGREE];
  logic [WIDTHOUT-1:0] sum_d  [1:DEGREE];

  state_t state_q, state_d;
  logic   adv;
  logic   accept;
  logic   pipe_busy;

  assign o_valid     = va_q[DEGREE];
  assign o_y         = acc_q[DEGREE];
  assign adv         = i_ready | ~o_valid;
  assign o_ready     = adv & (state_q == RUN);
  assign accept      = i_valid & o_ready;
  assign o_coef_busy = (state_q != RUN);
  assign pipe_busy   = (|va_q) | (|vm_q);

  // Per-stage multiply and coefficient add; stage pair j adds c_{N-j}
  always_comb begin
    for (int j = 1; j <= DEGREE; j++) begin
      prod_d[j] = mul_trunc(acc_q[j-1], xs_q[2*(j-1)]);
      sum_d[j]  = add_coef(prod_q[j], active[DEGREE-j]);
    end
  end

  // Pipeline registers advance together whenever the output can move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      va_q <= '0;
      vm_q <= '0;
      for (int k = 0; k <= DEGREE; k++) acc_q[k] <= '0;
      for (int j = 1; j <= DEGREE; j++) prod_q[j] <= '0;
      for (int i = 0; i < XLEN; i++) xs_q[i] <= '0;
    end else if (adv) begin
      va_q[0]  <= accept;
      acc_q[0] <= coef_ext(active[DEGREE]);
      xs_q[0]  <= i_x;
      for (int i = 1; i < XLEN; i++) xs_q[i] <= xs_q[i-1];
      for (int j = 1; j <= DEGREE; j++) begin
        vm_q[j]   <= va_q[j-1];
        prod_q[j] <= prod_d[j];
        va_q[j]   <= vm_q[j];
        acc_q[j]  <= sum_d[j];
      end
    end
  end

  // Shadow takes writes any time; active is only refreshed in SWAP, when
  // the pipe is empty, so every sample sees a single coefficient set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= DEGREE; k++) begin
        active[k] <= default_coef(k);
        shadow[k] <= default_coef(k);
      end
    end else begin
      if (i_coef_we && (int'(i_coef_addr) <= DEGREE)) shadow[i_coef_addr] <= i_coef_data;
      if (state_q == SWAP) begin
        for (int k = 0; k <= DEGREE; k++) active[k] <= shadow[k];
      end
    end
  end

  // Commit state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Commit sequencing: stop intake, wait for empty pipe, copy banks
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (i_coef_commit) state_d = DRAIN;
      DRAIN:   if (!pipe_busy)    state_d = SWAP;
      SWAP:                       state_d = RUN;
      default:                    state_d = RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_horner_poly_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_horner_poly_pipe                                          |
// | Description : Directed self-checking bench for horner_poly_pipe.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_horner_poly_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_x = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_y;
  logic        i_coef_we = 1'b0;
  logic [2:0]  i_coef_addr = '0;
  logic [15:0] i_coef_data = '0;
  logic        i_coef_commit = 1'b0;
  logic        o_coef_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] mc [0:5];
  logic [15:0] xq [$];
  logic [31:0] got [$];

  horner_poly_pipe dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_x           (i_x),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_y           (o_y),
    .i_coef_we     (i_coef_we),
    .i_coef_addr   (i_coef_addr),
    .i_coef_data   (i_coef_data),
    .i_coef_commit (i_coef_commit),
    .o_coef_busy   (o_coef_busy)
  );

  always #5 clk = ~clk;

  // Reference Horner evaluation for the coefficient set held in mc
  function automatic logic [31:0] model_y(input logic [15:0] x);
    logic [31:0] acc;
    logic [31:0] addend;
    logic [47:0] full;
    acc = 32'(mc[5]) << 11;
    for (int k = 4; k >= 0; k--) begin
      full   = 48'(acc) * 48'(x);
      acc    = 32'(full >> 14);
      addend = 32'(mc[k]) << 11;
`ifdef HORNER_SAT_EN
      if ((full >> 46) != 48'd0) acc = 32'hFFFF_FFFF;
      if (33'(acc) + 33'(addend) > 33'h0_FFFF_FFFF) acc = 32'hFFFF_FFFF;
      else acc = acc + addend;
`else
      acc = acc + addend;
`endif
    end
    return acc;
  endfunction

  task automatic set_exp_model();
    mc = '{16'h4000, 16'h4000, 16'h2000, 16'h0AAA, 16'h02AA, 16'h0088};
  endtask

  // Stream xq through the DUT with random downstream readiness; outputs land in got
  task automatic run_stream(input int ready_pct, input int max_cycles);
    int sent;
    sent = 0;
    got.delete();
    for (int cyc = 0; cyc < max_cycles && got.size() < xq.size(); cyc++) begin
      @(negedge clk);
      i_ready = ($urandom_range(0, 99) < ready_pct);
      i_valid = (sent < xq.size());
      i_x     = (sent < xq.size()) ? xq[sent] : 16'h0000;
      #1;
      if (i_valid && o_ready) sent++;
      if (o_valid && i_ready) got.push_back(o_y);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  // Push xq with downstream stalled until the pipe refuses more input
  task automatic fill_stalled(input int n, output int accepted);
    accepted = 0;
    i_ready  = 1'b0;
    for (int cyc = 0; cyc < 4 * n && accepted < n; cyc++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_x     = xq[accepted];
      #1;
      if (o_ready) accepted++;
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic write_coef(input int k, input logic [15:0] d);
    @(negedge clk);
    i_coef_we   = 1'b1;
    i_coef_addr = 3'(k);
    i_coef_data = d;
    @(negedge clk);
    i_coef_we   = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      #1;
      if (!o_coef_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    checks++; if (o_y !== 32'h0) begin errors++; $display("FAIL reset_o_y: got %h expected 00000000", o_y); end
    checks++; if (o_coef_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_coef_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready: got %b expected 1", o_ready); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // x=0 with default coefficients gives c0 = 1.0 after exactly 11 cycles
  task automatic test_latency();
    int early;
    early = 0;
    @(negedge clk);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_x     = 16'h0000;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      if (cyc < 11 && o_valid) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL latency_early: got %0d early valids expected 0", early); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b expected 1", o_valid); end
    checks++; if (o_y !== 32'h0200_0000) begin errors++; $display("FAIL latency_y: got %h expected 02000000", o_y); end
    @(negedge clk);
  endtask

  task automatic test_exp_vectors();
    logic [31:0] expv [0:2];
    expv = '{32'h0200_0000, 32'h056E_E000, 32'h0E87_8000};
    xq = '{16'h0000, 16'h4000, 16'h8000};
    run_stream(100, 60);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL exp_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== expv[i]) begin
        errors++; $display("FAIL exp_vec%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 32'hx, expv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    set_exp_model();
    xq.delete();
    for (int i = 0; i < 100; i++) xq.push_back(16'($urandom));
    run_stream(50, 2000);
    checks++; if (got.size() != 100) begin errors++; $display("FAIL b2b_count: got %0d expected 100", got.size()); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== model_y(xq[i])) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL b2b_sample%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 32'hx, model_y(xq[i]));
      end
    end
  endtask

  // Commit on an empty pipe; a write landing in the SWAP cycle stays in shadow
  task automatic test_commit();
    logic [31:0] expv [0:2];
    write_coef(0, 16'h0000);
    write_coef(1, 16'h4000);
    for (int k = 2; k < 6; k++) write_coef(k, 16'h0000);
    @(negedge clk);
    i_coef_commit = 1'b1;
    @(negedge clk);
    i_coef_commit = 1'b0;
    #1;
    checks++; if (o_coef_busy !== 1'b1) begin errors++; $display("FAIL commit_busy_drain: got %b expected 1", o_coef_busy); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL commit_ready_drain: got %b expected 0", o_ready); end
    @(negedge clk);
    i_coef_we   = 1'b1;
    i_coef_addr = 3'd0;
    i_coef_data = 16'h1234;
    #1;
    checks++; if (o_coef_busy !== 1'b1) begin errors++; $display("FAIL commit_busy_swap: got %b expected 1", o_coef_busy); end
    @(negedge clk);
    i_coef_we = 1'b0;
    #1;
    checks++; if (o_coef_busy !== 1'b0) begin errors++; $display("FAIL commit_busy_run: got %b expected 0", o_coef_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL commit_ready_run: got %b expected 1", o_ready); end
    expv = '{32'h0100_0000, 32'h0000_0000, 32'h07FF_F800};
    xq = '{16'h2000, 16'h0000, 16'hFFFF};
    run_stream(100, 60);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL commit_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== expv[i]) begin
        errors++; $display("FAIL commit_vec%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 32'hx, expv[i]);
      end
    end
  endtask

  // Commit with a full stalled pipe: old samples keep the old set
  task automatic test_commit_in_flight();
    int accepted;
    int bad_ready;
    int bad;
    bit done;
    write_coef(2, 16'h4000);
    xq.delete();
    for (int i = 1; i <= 11; i++) xq.push_back(16'(i * 16'h1111));
    fill_stalled(11, accepted);
    checks++; if (accepted != 11) begin errors++; $display("FAIL flight_fill: got %0d accepted expected 11", accepted); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b1 || o_y !== 32'h0088_8800 || o_ready !== 1'b0) begin
        errors++; $display("FAIL flight_hold%0d: got v=%b y=%h r=%b expected v=1 y=00888800 r=0", i, o_valid, o_y, o_ready);
      end
    end
    @(negedge clk);
    i_coef_commit = 1'b1;
    i_coef_we     = 1'b1;
    i_coef_addr   = 3'd0;
    i_coef_data   = 16'h0800;
    @(negedge clk);
    i_coef_commit = 1'b0;
    i_coef_we     = 1'b0;
    #1;
    checks++; if (o_coef_busy !== 1'b1) begin errors++; $display("FAIL flight_busy: got %b expected 1", o_coef_busy); end
    got.delete();
    bad_ready = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      i_ready = 1'b1;
      #1;
      if (o_coef_busy && o_ready) bad_ready++;
      if (o_valid && i_ready) got.push_back(o_y);
      if (!o_coef_busy) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL flight_timeout: got busy after 60 cycles expected idle"); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL flight_ready: got %0d ready cycles while busy expected 0", bad_ready); end
    checks++; if (got.size() != 11) begin errors++; $display("FAIL flight_count: got %0d expected 11", got.size()); end
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== (32'(xq[i]) << 11)) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL flight_old%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 32'hx, 32'(xq[i]) << 11);
      end
    end
    xq = '{16'h2000};
    run_stream(100, 60);
    checks++;
    if (got.size() != 1 || got[0] !== 32'h01C0_0000) begin
      errors++; $display("FAIL flight_new: got %h expected 01c00000", (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int k = 0; k < 6; k++) write_coef(k, 16'hFFFF);
    @(negedge clk);
    i_coef_commit = 1'b1;
    @(negedge clk);
    i_coef_commit = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_idle: got busy expected idle"); end
    mc = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    xq = '{16'hFFFF, 16'h0000};
    run_stream(100, 60);
    checks++;
    if (got.size() != 2 || got[0] !== model_y(16'hFFFF)) begin
      errors++; $display("FAIL sat_max: got %h expected %h", (got.size() > 0) ? got[0] : 32'hx, model_y(16'hFFFF));
    end
`ifdef HORNER_SAT_EN
    checks++;
    if (got.size() < 1 || got[0] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_clip: got %h expected ffffffff", (got.size() > 0) ? got[0] : 32'hx);
    end
`endif
    checks++;
    if (got.size() != 2 || got[1] !== 32'h07FF_F800) begin
      errors++; $display("FAIL sat_zero: got %h expected 07fff800", (got.size() > 1) ? got[1] : 32'hx);
    end
  endtask

  // Reset with a full pipe drops the data and restores the exp banks
  task automatic test_reset_midflight();
    int accepted;
    bit ok;
    xq.delete();
    for (int i = 0; i < 11; i++) xq.push_back(16'(16'h0400 + i));
    fill_stalled(11, accepted);
    checks++; if (accepted != 11 || o_valid !== 1'b1) begin errors++; $display("FAIL rst_fill: got %0d/%b expected 11/1", accepted, o_valid); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0 || o_y !== 32'h0) begin errors++; $display("FAIL rst_flush: got v=%b y=%h expected v=0 y=0", o_valid, o_y); end
    @(negedge clk);
    reset   = 1'b0;
    i_ready = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0 || o_coef_busy !== 1'b0) begin errors++; $display("FAIL rst_after: got v=%b busy=%b expected 0/0", o_valid, o_coef_busy); end
    xq = '{16'h0000, 16'h4000};
    run_stream(100, 60);
    checks++;
    if (got.size() != 2 || got[0] !== 32'h0200_0000 || got[1] !== 32'h056E_E000) begin
      errors++; $display("FAIL rst_active: got %0d outputs first %h expected 02000000,056ee000", got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
    @(negedge clk);
    i_coef_commit = 1'b1;
    @(negedge clk);
    i_coef_commit = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_commit_idle: got busy expected idle"); end
    xq = '{16'h8000};
    run_stream(100, 60);
    checks++;
    if (got.size() != 1 || got[0] !== 32'h0E87_8000) begin
      errors++; $display("FAIL rst_shadow: got %h expected 0e878000", (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  initial begin
    set_exp_model();
    test_reset();
    test_latency();
    test_exp_vectors();
    test_back_to_back();
    test_commit();
    test_commit_in_flight();
    test_saturation();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
